// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-stage branch predictor: branch-type encodings
// and the direction-counter reset/allocate values.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JUMP = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } br_type_e;

  // Weakly-not-taken: just below the taken threshold.
  function automatic int unsigned ctr_reset_val(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

  // Weakly-taken: the taken threshold itself.
  function automatic int unsigned ctr_alloc_val(input int unsigned ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Only compiled when BP_RAS_EN is defined.
`ifdef BP_RAS_EN
module bp_ras #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [XLEN-1:0]  push_data,
  input  logic             pop,
  output logic [XLEN-1:0]  top,
  output logic [CNT_W-1:0] count
);

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;  // next free slot
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] ptr_inc, ptr_dec;

  assign ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - PTR_W'(1);
  assign top     = mem_q[ptr_dec];
  assign count   = count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[ptr_q] <= push_data;
      ptr_q        <= ptr_inc;
      if (count_q != CNT_W'(DEPTH)) count_q <= count_q + CNT_W'(1);
    end else if (pop && (count_q != '0)) begin
      ptr_q   <= ptr_dec;
      count_q <= count_q - CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor with saturating direction counters.
// Define BP_RAS_EN to add a return-address stack for return targets.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned TAG_W     = 12,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] f_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [1:0]      upd_type,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispredict,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_RESET = CTR_W'(ctr_reset_val(CTR_W));
  localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(ctr_alloc_val(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX   = '1;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  br_type_e           type_q   [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [31:0]        stat_br_q, stat_mis_q;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  br_type_e         u_type;
  logic             u_hit, u_taken;

  assign f_idx   = f_pc[IDX_W-1:0];
  assign f_tag   = f_pc[IDX_W+TAG_W-1:IDX_W];
  assign u_idx   = upd_pc[IDX_W-1:0];
  assign u_tag   = upd_pc[IDX_W+TAG_W-1:IDX_W];
  assign u_type  = br_type_e'(upd_type);
  assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_taken = upd_taken || (u_type != BR_COND);

  logic unused_upd_pc;
  assign unused_upd_pc = ^upd_pc;

`ifdef BP_RAS_EN
  localparam int unsigned RAS_CNT_W = $clog2(RAS_DEPTH + 1);
  logic [XLEN-1:0]      ras_top;
  logic [RAS_CNT_W-1:0] ras_count;

  // Trained from resolved instructions only, so no speculative repair needed.
  bp_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (upd_valid && (u_type == BR_CALL)),
    .push_data (upd_pc + XLEN'(1)),
    .pop       (upd_valid && (u_type == BR_RET)),
    .top       (ras_top),
    .count     (ras_count)
  );
`else
  logic [31:0] unused_ras_depth;
  assign unused_ras_depth = 32'(RAS_DEPTH);
`endif

  always_comb begin
    pred_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = 1'b0;
    pred_target = f_pc + XLEN'(1);
    if (pred_hit) begin
      pred_taken = (type_q[f_idx] == BR_COND) ? ctr_q[f_idx][CTR_W-1] : 1'b1;
    end
    if (pred_taken) begin
      pred_target = target_q[f_idx];
`ifdef BP_RAS_EN
      if ((type_q[f_idx] == BR_RET) && (ras_count != '0)) pred_target = ras_top;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        type_q[i]   <= BR_COND;
        ctr_q[i]    <= CTR_RESET;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        if (u_type == BR_COND) begin
          if (upd_taken) begin
            target_q[u_idx] <= upd_target;
            if (ctr_q[u_idx] != CTR_MAX) ctr_q[u_idx] <= ctr_q[u_idx] + CTR_W'(1);
          end else if (ctr_q[u_idx] != '0) begin
            ctr_q[u_idx] <= ctr_q[u_idx] - CTR_W'(1);
          end
        end else begin
          target_q[u_idx] <= upd_target;
          type_q[u_idx]   <= u_type;
        end
      end else if (u_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        type_q[u_idx]   <= u_type;
        ctr_q[u_idx]    <= CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else if (upd_valid) begin
      if (stat_br_q != '1) stat_br_q <= stat_br_q + 32'd1;
      if (upd_mispredict && (stat_mis_q != '1)) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed stimulus queues expected
// lookups/stats, a negedge monitor pops and compares.
module tb_branch_predictor;

  localparam logic [1:0] T_COND = 2'd0;
  localparam logic [1:0] T_JUMP = 2'd1;
  localparam logic [1:0] T_CALL = 2'd2;
  localparam logic [1:0] T_RET  = 2'd3;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] f_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_taken, upd_mispredict;
  logic [31:0] upd_pc, upd_target;
  logic [1:0]  upd_type;
  logic [31:0] stat_branches, stat_mispredicts;

  always #5 clock = ~clock;

  branch_predictor dut (
    .clock            (clock),
    .reset            (reset),
    .f_pc             (f_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_type         (upd_type),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  typedef struct {
    string       name;
    bit          is_stat;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t sbq[$];
  exp_t m;
  bit   chk = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(negedge clock) begin
    if (chk) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard: got an output to check, want a queued expectation");
      end else begin
        m = sbq.pop_front();
        if (m.is_stat) begin
          if (stat_branches !== m.sb || stat_mispredicts !== m.sm) begin
            n_bad++;
            $display("FAIL %s: got branches=%0d mispredicts=%0d, want branches=%0d mispredicts=%0d",
                     m.name, stat_branches, stat_mispredicts, m.sb, m.sm);
          end
        end else if (pred_hit !== m.hit || pred_taken !== m.taken || pred_target !== m.tgt) begin
          n_bad++;
          $display("FAIL %s: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                   m.name, pred_hit, pred_taken, pred_target, m.hit, m.taken, m.tgt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_cycle();
    chk = 1'b1;
    @(negedge clock);
    #1 chk = 1'b0;
    tick();
  endtask

  task automatic look(input string nm, input logic [31:0] pc, input logic h, input logic t,
                      input logic [31:0] tg);
    exp_t e;
    f_pc      = pc;
    e.name    = nm;
    e.is_stat = 1'b0;
    e.hit     = h;
    e.taken   = t;
    e.tgt     = tg;
    e.sb      = '0;
    e.sm      = '0;
    sbq.push_back(e);
    check_cycle();
  endtask

  task automatic stat(input string nm, input logic [31:0] b, input logic [31:0] mp);
    exp_t e;
    e.name    = nm;
    e.is_stat = 1'b1;
    e.hit     = 1'b0;
    e.taken   = 1'b0;
    e.tgt     = '0;
    e.sb      = b;
    e.sm      = mp;
    sbq.push_back(e);
    check_cycle();
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [1:0] ty, input logic tk,
                         input logic [31:0] tg, input logic mis);
    upd_pc         = pc;
    upd_type       = ty;
    upd_taken      = tk;
    upd_target     = tg;
    upd_mispredict = mis;
    upd_valid      = 1'b1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [1:0] ty, input logic tk,
                     input logic [31:0] tg, input logic mis);
    set_upd(pc, ty, tk, tg, mis);
    tick();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ras_exp [6];
    reset = 1'b0;
    f_pc = 32'h10;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_type = T_COND;
    upd_taken = 1'b0;
    upd_target = '0;
    upd_mispredict = 1'b0;
    repeat (2) tick();

    look("reset_lookup", 32'h10, 1'b0, 1'b0, 32'h11);
    stat("reset_stats", 32'd0, 32'd0);
    reset = 1'b1;
    tick();

    // Direction counter training and saturation at both ends
    upd(32'h10, T_COND, 1'b1, 32'h40, 1'b0);
    look("cond_alloc", 32'h10, 1'b1, 1'b1, 32'h40);
    upd(32'h10, T_COND, 1'b0, 32'h40, 1'b0);
    look("cond_nt1", 32'h10, 1'b1, 1'b0, 32'h11);
    upd(32'h10, T_COND, 1'b0, 32'h40, 1'b0);
    look("cond_nt2", 32'h10, 1'b1, 1'b0, 32'h11);
    upd(32'h10, T_COND, 1'b0, 32'h40, 1'b0);
    upd(32'h10, T_COND, 1'b1, 32'h40, 1'b0);
    look("floor_sat", 32'h10, 1'b1, 1'b0, 32'h11);
    upd(32'h10, T_COND, 1'b1, 32'h40, 1'b0);
    look("cond_t2", 32'h10, 1'b1, 1'b1, 32'h40);
    repeat (3) upd(32'h10, T_COND, 1'b1, 32'h40, 1'b0);
    look("ceil_sat", 32'h10, 1'b1, 1'b1, 32'h40);
    upd(32'h10, T_COND, 1'b0, 32'h40, 1'b0);
    look("ceil_nt1", 32'h10, 1'b1, 1'b1, 32'h40);
    upd(32'h10, T_COND, 1'b0, 32'h40, 1'b0);
    look("ceil_nt2", 32'h10, 1'b1, 1'b0, 32'h11);
    upd(32'h10, T_COND, 1'b1, 32'h44, 1'b0);
    look("cond_retarget", 32'h10, 1'b1, 1'b1, 32'h44);

    // Aliasing in a 16-entry table and no allocation on not-taken
    upd(32'h10, T_JUMP, 1'b1, 32'h40, 1'b0);
    look("jump_hit", 32'h10, 1'b1, 1'b1, 32'h40);
    upd(32'h20, T_JUMP, 1'b1, 32'h80, 1'b0);
    look("alias_evicted", 32'h10, 1'b0, 1'b0, 32'h11);
    look("alias_new", 32'h20, 1'b1, 1'b1, 32'h80);
    upd(32'h30, T_COND, 1'b0, 32'h99, 1'b0);
    look("nt_no_alloc", 32'h30, 1'b0, 1'b0, 32'h31);
    look("nt_kept_old", 32'h20, 1'b1, 1'b1, 32'h80);
    upd(32'h60, T_JUMP, 1'b0, 32'h90, 1'b0);
    look("jump_forced_taken", 32'h60, 1'b1, 1'b1, 32'h90);

    // Same-cycle lookup sees pre-update state
    upd(32'h10, T_JUMP, 1'b1, 32'h40, 1'b0);
    set_upd(32'h10, T_JUMP, 1'b1, 32'h50, 1'b0);
    look("same_cycle_old", 32'h10, 1'b1, 1'b1, 32'h40);
    upd_valid = 1'b0;
    look("same_cycle_new", 32'h10, 1'b1, 1'b1, 32'h50);

    // Async reset mid-sequence, with an update pending across the edge
    set_upd(32'h40, T_JUMP, 1'b1, 32'h77, 1'b1);
    reset = 1'b0;
    look("async_reset", 32'h10, 1'b0, 1'b0, 32'h11);
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
    stat("reset_clears_stats", 32'd0, 32'd0);
    reset = 1'b1;
    look("reset_drops_upd", 32'h40, 1'b0, 1'b0, 32'h41);

    // Statistics
    for (int i = 0; i < 10; i++) begin
      upd(32'h200 + 32'(i), T_JUMP, 1'b1, 32'h300 + 32'(i), (i % 3 == 0) && (i < 9));
    end
    upd_mispredict = 1'b1;
    tick();
    upd_mispredict = 1'b0;
    stat("stats_10_3", 32'd10, 32'd3);

`ifdef BP_RAS_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    upd(32'h303, T_RET, 1'b1, 32'h999, 1'b0);
    look("ras_empty_btb", 32'h303, 1'b1, 1'b1, 32'h999);
    upd(32'h100, T_CALL, 1'b1, 32'h500, 1'b0);
    upd(32'h200, T_CALL, 1'b1, 32'h600, 1'b0);
    look("ras_top", 32'h303, 1'b1, 1'b1, 32'h201);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    upd(32'h3F, T_RET, 1'b1, 32'h999, 1'b0);
    for (int i = 1; i <= 5; i++) upd(32'h11 * 32'(i), T_CALL, 1'b1, 32'h700, 1'b0);
    ras_exp[0] = 32'h56;
    ras_exp[1] = 32'h45;
    ras_exp[2] = 32'h34;
    ras_exp[3] = 32'h23;
    ras_exp[4] = 32'h999;
    ras_exp[5] = 32'h999;
    for (int k = 0; k < 5; k++) begin
      look($sformatf("ras_pop%0d", k), 32'h3F, 1'b1, 1'b1, ras_exp[k]);
      upd(32'h3F, T_RET, 1'b1, 32'h999, 1'b0);
    end
    look("ras_empty_pop", 32'h3F, 1'b1, 1'b1, ras_exp[5]);
`endif

    if (sbq.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised fetch-stage branch predictor for the 5-stage pipeline.
- Replaces the fixed predict-not-taken policy, which flushes F/D on every taken branch resolved in X.
- Direct-mapped BTB; each entry holds a tag, a target, a branch type and a saturating direction counter.
- Lookup is combinational from the fetch PC. Training happens when X resolves a control-flow instruction.

Parameters:
- XLEN, 32, width of PC and target.
- ENTRIES, 16, BTB entries; must be a power of 2. IDX_W = log2(ENTRIES).
- TAG_W, 12, tag bits taken from pc[IDX_W+TAG_W-1:IDX_W].
- CTR_W, 2, direction counter width; min 1, max 4.
- RAS_DEPTH, 4, return-stack depth; used only with BP_RAS_EN.

Ports:
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_pc  in  XLEN  fetch PC for lookup.
- pred_hit  out  1  valid tag match at f_pc.
- pred_taken  out  1  predict redirect.
- pred_target  out  XLEN  predicted next PC; equals f_pc+1 when pred_taken=0.
- upd_valid  in  1  X stage resolved a control-flow instruction this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_type  in  2  0 = conditional, 1 = jump, 2 = call, 3 = return.
- upd_taken  in  1  actual direction; forced 1 for types 1–3.
- upd_target  in  XLEN  actual taken target.
- upd_mispredict  in  1  X detected a wrong prediction; qualified by upd_valid.
- stat_branches  out  32  count of upd_valid cycles.
- stat_mispredicts  out  32  count of upd_valid & upd_mispredict cycles.

Behaviour:
- Reset (reset=0, async):
  - all valid bits cleared; counters set to weakly-not-taken, 2^(CTR_W-1)-1.
  - stats = 0; RAS pointer and count = 0.
  - outputs: pred_hit=0, pred_taken=0, pred_target=f_pc+1.
- Lookup (combinational, 0 cycles):
  - idx = f_pc[IDX_W-1:0]; hit = valid[idx] & (tag[idx] == f_pc tag field).
  - hit & conditional: taken = counter MSB.
  - hit & jump/call/return: taken = 1.
  - pred_target = entry target if taken, else f_pc+1.
  - Miss: not taken.
- Update (rising edge, upd_valid=1), same indexing from upd_pc:
  - Hit, conditional: counter +1 if taken, -1 if not; saturates at 0 and 2^CTR_W-1. Target overwritten when taken.
  - Hit, other types: target and type overwritten.
  - Miss and upd_taken=1: allocate or replace the entry; counter = weakly-taken 2^(CTR_W-1); store tag, target, type.
  - Miss and not taken: no allocation.
- Same-cycle lookup and update of the same entry: lookup returns pre-update state; the new state is visible next cycle.
- Stats: each increments by 1 per qualifying cycle and saturates at 2^32-1 (no wrap).
- upd_mispredict with upd_valid=0: ignored.
- Stall: no stall input. The PC register holds f_pc stable and outputs are combinational, so repeated lookups are harmless.
- Reset mid-update: reset wins and the update is discarded.

Optional Feature:
- Macro: BP_RAS_EN.
- Defined — a return-address stack of RAS_DEPTH entries, updated non-speculatively on update:
  - call pushes upd_pc+1.
  - return pops.
  - Full push: circular overwrite of the oldest entry; count stays RAS_DEPTH.
  - Empty pop: ignored.
  - Lookup hit of type return: pred_target = RAS top when count>0, else the BTB target.
- Not defined: no RAS storage; return entries predict the BTB target; RAS_DEPTH unused.

Decomposition:
- Shared package (existing processor constants file):
  - branch-type encodings BR_COND, BR_JUMP, BR_CALL, BR_RET;
  - counter reset and allocate constants as functions of CTR_W.
- One natural sub-module, bp_ras: the circular stack with push, pop, top, count. Instantiated only under BP_RAS_EN.

Test Plan:
- Reset, then lookup of f_pc=0x10 → pred_hit=0, pred_taken=0, pred_target=0x11; both stats = 0.
- Update pc=0x10, cond, taken, target 0x40 → next cycle lookup 0x10 gives hit=1, taken=1, target=0x40. Two not-taken updates → taken=0. Four taken updates → counter saturates at 3, and a fifth leaves it 3.
- Alias with ENTRIES=16: entry at 0x10 (jump→0x40), then update pc=0x20 (jump→0x80) → lookup 0x10 misses, 0x20 hits with target 0x80. A not-taken conditional at 0x30 does not allocate.
- Same-cycle: lookup 0x10 while updating 0x10 to target 0x50 → this cycle returns 0x40, next cycle 0x50. Assert reset low mid-sequence → hit=0 immediately, without waiting for a clock edge.
- Stats: 10 updates, 3 with upd_mispredict → stat_branches=10, stat_mispredicts=3. upd_mispredict with upd_valid=0 → no change.
- BP_RAS_EN, RAS_DEPTH=4:
  - calls at 0x100 and 0x200, then return at 0x300 updated with target 0x999 → lookup 0x300 predicts 0x201.
  - 5 calls then 5 returns → tops 0x?+1 in LIFO order for the last 4; the fifth pop is ignored and falls back to the BTB target.
